// File: rtl/mem_sched_pkg.sv
// Shared types and helpers for the two-requester memory access scheduler.
package mem_sched_pkg;

    localparam int NREQ   = 2;
    localparam int CMD_AW = 32;
    localparam int CMD_DW = 32;

    // One memory-bus command as it is registered toward the memory.
    typedef struct packed {
        logic              write;
        logic              read;
        logic [CMD_AW-1:0] addr;
        logic [CMD_DW-1:0] wdata;
    } cmd_t;

    // Tag carried alongside a read so its data can be routed back to the issuer.
    typedef struct packed {
        logic valid;
        logic id;
    } rtag_t;

    // Round-robin pick between two eligible requesters; last is the previous winner.
    function automatic logic [NREQ-1:0] rr_pick(input logic [NREQ-1:0] elig, input logic last);
        rr_pick = elig;
        if (elig == 2'b11) begin
            rr_pick = last ? 2'b01 : 2'b10;
        end
    endfunction

endpackage

// File: rtl/mem_access_sched_if.sv
// Requester handshake plus memory-bus signals of the scheduler.
interface mem_access_sched_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    // A requester raises req[i] with we/addr/wdata stable and holds them until it
    // sees gnt[i] high in the same cycle; it may change or drop them the cycle after.
    logic [1:0]    req;
    logic [1:0]    we;
    logic [AW-1:0] req_addr0;
    logic [AW-1:0] req_addr1;
    logic [DW-1:0] req_wdata0;
    logic [DW-1:0] req_wdata1;
    logic [1:0]    gnt;
    logic [1:0]    rvalid;
    logic [DW-1:0] rdata_o;
    logic          rd_served;
    logic          write;
    logic          read;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          wr_valid;
    logic [DW-1:0] rdata;

    modport slave (
        input  req, we, req_addr0, req_addr1, req_wdata0, req_wdata1, rdata,
        output gnt, rvalid, rdata_o, rd_served, write, read, addr, wdata, wr_valid
    );

    modport master (
        output req, we, req_addr0, req_addr1, req_wdata0, req_wdata1, rdata,
        input  gnt, rvalid, rdata_o, rd_served, write, read, addr, wdata, wr_valid
    );

endinterface

// File: rtl/rd_tag_pipe.sv
// Read tag delay line: aligns each read's requester id with its returning data.
module rd_tag_pipe
    import mem_sched_pkg::*;
#(
    parameter int RD_LAT = 0,
    parameter int DW     = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  rtag_t           i_tag,
    input  logic [DW-1:0]   i_rdata,
    output logic [NREQ-1:0] o_rvalid,
    output logic [DW-1:0]   o_rdata,
    output logic            o_rd_served
);

    // Entry 0 lines up with the cycle the read is on the bus; entry RD_LAT with its data.
    rtag_t [RD_LAT:0] r_pipe;
    rtag_t            w_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pipe <= '0;
        end else begin
            r_pipe[0] <= i_tag;
            for (int k = 1; k <= RD_LAT; k++) begin
                r_pipe[k] <= r_pipe[k-1];
            end
        end
    end

    assign w_out       = r_pipe[RD_LAT];
    assign o_rvalid    = {w_out.valid & w_out.id, w_out.valid & ~w_out.id};
    assign o_rd_served = w_out.valid;
    assign o_rdata     = w_out.valid ? i_rdata : '0;

endmodule

// File: rtl/mem_access_sched.sv
// Round-robin scheduler of two requesters onto one single-port memory bus.
module mem_access_sched
    import mem_sched_pkg::*;
#(
    parameter int AW     = 32,
    parameter int DW     = 32,
    parameter int RD_LAT = 0
) (
    input  logic               clk,
    input  logic               rst,
    mem_access_sched_if.slave  bus
);

    cmd_t            r_cmd;
    logic            r_last_gnt;
    logic [NREQ-1:0] w_haz;
    logic [NREQ-1:0] w_elig;
    logic [NREQ-1:0] w_gnt;
    logic            w_id;
    logic            w_we;
    rtag_t           w_tag;

    // A write matching the write now on the bus sits out one cycle.
    assign w_haz[0] = bus.we[0] & r_cmd.write & (bus.req_addr0 == r_cmd.addr[AW-1:0]);
    assign w_haz[1] = bus.we[1] & r_cmd.write & (bus.req_addr1 == r_cmd.addr[AW-1:0]);
    assign w_elig   = bus.req & ~w_haz;
    assign w_gnt    = rst ? '0 : rr_pick(w_elig, r_last_gnt);
    assign w_id     = w_gnt[1];
    assign w_we     = bus.we[w_id];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cmd      <= '0;
            r_last_gnt <= 1'b1;
        end else begin
            r_cmd.write <= (|w_gnt) & w_we;
            r_cmd.read  <= (|w_gnt) & ~w_we;
            if (|w_gnt) begin
                r_cmd.addr  <= CMD_AW'(w_id ? bus.req_addr1 : bus.req_addr0);
                r_cmd.wdata <= CMD_DW'(w_id ? bus.req_wdata1 : bus.req_wdata0);
                r_last_gnt  <= w_id;
            end
        end
    end

    assign w_tag.valid = (|w_gnt) & ~w_we;
    assign w_tag.id    = w_id;

    rd_tag_pipe #(
        .RD_LAT (RD_LAT),
        .DW     (DW)
    ) u_rd_tag_pipe (
        .clk         (clk),
        .rst         (rst),
        .i_tag       (w_tag),
        .i_rdata     (bus.rdata),
        .o_rvalid    (bus.rvalid),
        .o_rdata     (bus.rdata_o),
        .o_rd_served (bus.rd_served)
    );

    assign bus.gnt      = w_gnt;
    assign bus.write    = r_cmd.write;
    assign bus.read     = r_cmd.read;
    assign bus.addr     = r_cmd.addr[AW-1:0];
    assign bus.wdata    = r_cmd.wdata[DW-1:0];
    assign bus.wr_valid = r_cmd.write;

endmodule

// File: tb/tb_mem_access_sched.sv
// Bench for mem_access_sched: three read latencies driven with identical requests.
module tb_mem_access_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req, we;
    logic [31:0] a0, a1, d0, d1;
    logic [23:0] rd_cnt = '0;
    logic [31:0] mem_rdata;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always #5 clk = ~clk;
    always @(posedge clk) rd_cnt <= rd_cnt + 24'd1;
    assign mem_rdata = {rd_cnt, 8'hAB};

    mem_access_sched_if #(.AW(32), .DW(32)) if_l0 ();
    mem_access_sched_if #(.AW(32), .DW(32)) if_l2 ();
    mem_access_sched_if #(.AW(32), .DW(32)) if_l3 ();

    assign if_l0.req = req;  assign if_l0.we = we;
    assign if_l0.req_addr0 = a0;  assign if_l0.req_addr1 = a1;
    assign if_l0.req_wdata0 = d0; assign if_l0.req_wdata1 = d1;
    assign if_l0.rdata = mem_rdata;
    assign if_l2.req = req;  assign if_l2.we = we;
    assign if_l2.req_addr0 = a0;  assign if_l2.req_addr1 = a1;
    assign if_l2.req_wdata0 = d0; assign if_l2.req_wdata1 = d1;
    assign if_l2.rdata = mem_rdata;
    assign if_l3.req = req;  assign if_l3.we = we;
    assign if_l3.req_addr0 = a0;  assign if_l3.req_addr1 = a1;
    assign if_l3.req_wdata0 = d0; assign if_l3.req_wdata1 = d1;
    assign if_l3.rdata = mem_rdata;

    mem_access_sched #(.AW(32), .DW(32), .RD_LAT(0)) u_l0 (.clk(clk), .rst(rst), .bus(if_l0.slave));
    mem_access_sched #(.AW(32), .DW(32), .RD_LAT(2)) u_l2 (.clk(clk), .rst(rst), .bus(if_l2.slave));
    mem_access_sched #(.AW(32), .DW(32), .RD_LAT(3)) u_l3 (.clk(clk), .rst(rst), .bus(if_l3.slave));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Behavioural model: expected bus command now, round-robin memory, read history.
    logic        m_wr = 1'b0, m_rd = 1'b0, m_last = 1'b1;
    logic [31:0] m_ad = '0, m_wd = '0;
    bit          hist_rd [0:4095];
    bit          hist_id [0:4095];
    int          last_rst = -1;
    logic [1:0]  el, eg;
    logic        prev_wr [3];
    logic [31:0] prev_ad [3];

    function automatic logic [1:0] exp_rv(input int lat);
        int u;
        u = cyc - lat;
        exp_rv = 2'b00;
        if (u >= 0 && hist_rd[u] && last_rst < u) exp_rv = hist_id[u] ? 2'b10 : 2'b01;
    endfunction

    task automatic check_inst(input int k, input int lat, input logic [1:0] g, input logic [1:0] rv,
                              input logic [31:0] rdo, input logic rs, input logic wr, input logic rd,
                              input logic [31:0] ad, input logic [31:0] wd, input logic wv);
        logic [1:0] ev;
        ev = exp_rv(lat);
        chk($sformatf("gnt_l%0d", lat), 32'(g), 32'(eg));
        chk($sformatf("write_l%0d", lat), 32'(wr), 32'(m_wr));
        chk($sformatf("read_l%0d", lat), 32'(rd), 32'(m_rd));
        chk($sformatf("addr_l%0d", lat), ad, m_ad);
        chk($sformatf("wdata_l%0d", lat), wd, m_wd);
        chk($sformatf("wr_valid_l%0d", lat), 32'(wv), 32'(m_wr));
        chk($sformatf("rvalid_l%0d", lat), 32'(rv), 32'(ev));
        chk($sformatf("rd_served_l%0d", lat), 32'(rs), 32'(ev != 2'b00));
        chk($sformatf("rdata_o_l%0d", lat), rdo, (ev != 2'b00) ? mem_rdata : 32'h0);
        chk($sformatf("gnt_onehot_l%0d", lat), 32'($countones(g) > 1), 32'h0);
        chk($sformatf("wr_rd_excl_l%0d", lat), 32'(wr & rd), 32'h0);
        chk($sformatf("b2b_same_addr_wr_l%0d", lat), 32'(wr && prev_wr[k] && ad == prev_ad[k]), 32'h0);
        prev_wr[k] = wr;
        prev_ad[k] = ad;
    endtask

    always @(negedge clk) begin
        el[0] = req[0] && !(we[0] && m_wr && a0 == m_ad);
        el[1] = req[1] && !(we[1] && m_wr && a1 == m_ad);
        if (rst)              eg = 2'b00;
        else if (el == 2'b11) eg = m_last ? 2'b01 : 2'b10;
        else if (el[0])       eg = 2'b01;
        else if (el[1])       eg = 2'b10;
        else                  eg = 2'b00;
        if (cyc >= 1) begin
            check_inst(0, 0, if_l0.gnt, if_l0.rvalid, if_l0.rdata_o, if_l0.rd_served,
                       if_l0.write, if_l0.read, if_l0.addr, if_l0.wdata, if_l0.wr_valid);
            check_inst(1, 2, if_l2.gnt, if_l2.rvalid, if_l2.rdata_o, if_l2.rd_served,
                       if_l2.write, if_l2.read, if_l2.addr, if_l2.wdata, if_l2.wr_valid);
            check_inst(2, 3, if_l3.gnt, if_l3.rvalid, if_l3.rdata_o, if_l3.rd_served,
                       if_l3.write, if_l3.read, if_l3.addr, if_l3.wdata, if_l3.wr_valid);
        end
        hist_rd[cyc+1] = 1'b0;
        if (rst) begin
            m_wr = 1'b0; m_rd = 1'b0; m_ad = '0; m_wd = '0; m_last = 1'b1;
            last_rst = cyc;
        end else if (eg != 2'b00) begin
            m_wr   = we[eg[1]];
            m_rd   = !we[eg[1]];
            m_ad   = eg[1] ? a1 : a0;
            m_wd   = eg[1] ? d1 : d0;
            m_last = eg[1];
            hist_rd[cyc+1] = !we[eg[1]];
            hist_id[cyc+1] = eg[1];
        end else begin
            m_wr = 1'b0;
            m_rd = 1'b0;
        end
        cyc++;
    end

    task automatic to_neg();
        @(negedge clk);
    endtask

    task automatic to_next();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] r, input logic [1:0] w, input logic [31:0] ad0,
                         input logic [31:0] wd0, input logic [31:0] ad1, input logic [31:0] wd1);
        req = r; we = w; a0 = ad0; d0 = wd0; a1 = ad1; d1 = wd1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        drive(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
        to_next();
        rst = 1'b0;
    endtask

    logic [1:0] seq2 [4] = '{2'b01, 2'b10, 2'b01, 2'b10};

    initial begin
        for (int i = 0; i < 3; i++) begin
            prev_wr[i] = 1'b0;
            prev_ad[i] = '0;
        end
        rst = 1'b1;
        drive(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
        to_next();
        to_next();
        rst = 1'b0;

        // Single read through the two-cycle-latency instance.
        apply_reset();
        to_neg();
        chk("t1_reset_write", 32'(if_l2.write), 32'h0);
        chk("t1_reset_addr", if_l2.addr, 32'h0);
        to_next();
        drive(2'b01, 2'b00, 32'h10, 32'h0, 32'h0, 32'h0);
        to_neg();
        chk("t1_gnt", 32'(if_l2.gnt), 32'h1);
        to_next();
        drive(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
        to_neg();
        chk("t1_read", 32'(if_l2.read), 32'h1);
        chk("t1_addr", if_l2.addr, 32'h10);
        to_next();
        to_neg();
        chk("t1_rvalid_early", 32'(if_l2.rvalid), 32'h0);
        to_next();
        to_neg();
        chk("t1_rvalid", 32'(if_l2.rvalid), 32'h1);
        chk("t1_rdata", 32'(if_l2.rdata_o[7:0]), 32'hAB);
        chk("t1_served", 32'(if_l2.rd_served), 32'h1);
        to_next();

        // Both requesters reading continuously alternate.
        apply_reset();
        drive(2'b11, 2'b00, 32'h40, 32'h0, 32'h44, 32'h0);
        for (int k = 0; k < 4; k++) begin
            to_neg();
            chk($sformatf("t2_gnt%0d", k), 32'(if_l0.gnt), 32'(seq2[k]));
            to_next();
        end
        drive(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
        to_next();

        // Same-address writes from one requester are spaced by an idle cycle.
        apply_reset();
        drive(2'b01, 2'b01, 32'h20, 32'h11, 32'h0, 32'h0);
        to_neg();
        chk("t3_gnt_first", 32'(if_l0.gnt), 32'h1);
        to_next();
        d0 = 32'h22;
        to_neg();
        chk("t3_write_first", 32'(if_l0.write), 32'h1);
        chk("t3_gnt_hazard", 32'(if_l0.gnt), 32'h0);
        to_next();
        to_neg();
        chk("t3_idle", 32'(if_l0.write), 32'h0);
        chk("t3_gnt_second", 32'(if_l0.gnt), 32'h1);
        to_next();
        drive(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
        to_neg();
        chk("t3_write_second", 32'(if_l0.write), 32'h1);
        chk("t3_wdata_second", if_l0.wdata, 32'h22);
        to_next();

        // A read from the other requester fills the hazard slot.
        apply_reset();
        drive(2'b11, 2'b01, 32'h20, 32'h33, 32'h30, 32'h0);
        to_neg();
        chk("t4_gnt0", 32'(if_l0.gnt), 32'h1);
        to_next();
        d0 = 32'h44;
        to_neg();
        chk("t4_gnt1", 32'(if_l0.gnt), 32'h2);
        chk("t4_bus_wr", 32'(if_l0.write), 32'h1);
        chk("t4_bus_wr_addr", if_l0.addr, 32'h20);
        to_next();
        req = 2'b01;
        to_neg();
        chk("t4_gnt2", 32'(if_l0.gnt), 32'h1);
        chk("t4_bus_rd", 32'(if_l0.read), 32'h1);
        chk("t4_bus_rd_addr", if_l0.addr, 32'h30);
        to_next();
        drive(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
        to_neg();
        chk("t4_bus_wr2", 32'(if_l0.write), 32'h1);
        chk("t4_bus_wr2_data", if_l0.wdata, 32'h44);
        to_next();

        // Zero latency: rvalid follows the bus read in the same cycle.
        apply_reset();
        drive(2'b01, 2'b00, 32'h50, 32'h0, 32'h54, 32'h0);
        to_neg();
        to_next();
        req = 2'b10;
        to_neg();
        chk("t5_rv0", 32'(if_l0.rvalid), 32'h1);
        chk("t5_served0", 32'(if_l0.rd_served), 32'h1);
        to_next();
        req = 2'b01;
        to_neg();
        chk("t5_rv1", 32'(if_l0.rvalid), 32'h2);
        to_next();
        req = 2'b00;
        to_neg();
        chk("t5_rv2", 32'(if_l0.rvalid), 32'h1);
        to_next();
        to_neg();
        chk("t5_rv_idle", 32'(if_l0.rvalid), 32'h0);
        chk("t5_served_idle", 32'(if_l0.rd_served), 32'h0);
        to_next();

        // Reset with two reads in flight on the three-cycle-latency instance.
        apply_reset();
        drive(2'b11, 2'b00, 32'h60, 32'h0, 32'h64, 32'h0);
        to_next();
        to_next();
        rst = 1'b1;
        req = 2'b00;
        to_neg();
        chk("t6_gnt_in_rst", 32'(if_l3.gnt), 32'h0);
        to_next();
        rst = 1'b0;
        to_neg();
        chk("t6_write", 32'(if_l3.write), 32'h0);
        chk("t6_read", 32'(if_l3.read), 32'h0);
        chk("t6_addr", if_l3.addr, 32'h0);
        chk("t6_wdata", if_l3.wdata, 32'h0);
        chk("t6_rdata_o", if_l3.rdata_o, 32'h0);
        chk("t6_gnt", 32'(if_l3.gnt), 32'h0);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("t6_rvalid%0d", k), 32'(if_l3.rvalid), 32'h0);
            to_next();
            to_neg();
        end
        to_next();

        repeat (3) to_next();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mem_access_sched.md
Name: mem_access_sched

Overview:
- Two-requester scheduler for a single-port synchronous memory.
- Arbitrates read/write requests round-robin and issues one registered command per cycle on the memory bus (write, read, addr, wdata, wr_valid).
- Tags each read and routes returning rdata to the requester that issued it, after RD_LAT cycles.
- Never issues two back-to-back writes to the same address; the memory-side property checker flags consecutive writes that share an address.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- RD_LAT, 0, cycles from a read command on the bus to valid rdata (legal 0..4).

Ports:
- clk  in  1  clock, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- req  in  2  per-requester request; held until granted.
- we  in  2  per-requester op: 1 = write, 0 = read.
- req_addr0, req_addr1  in  AW each  request address.
- req_wdata0, req_wdata1  in  DW each  write data.
- gnt  out  2  one-hot grant pulse, combinational, same cycle as the accepted request.
- rvalid  out  2  one-hot read-return strobe.
- rdata_o  out  DW  read data, meaningful when rvalid is nonzero.
- write  out  1  memory write command (registered).
- read  out  1  memory read command (registered).
- addr  out  AW  memory address (registered).
- wdata  out  DW  memory write data (registered).
- wr_valid  out  1  equals write; feeds the checker.
- rdata  in  DW  memory read data.
- rd_served  out  1  high when any rvalid bit is high.

Behaviour:
- Reset values:
  - write, read, wr_valid, rd_served, gnt, rvalid all 0.
  - addr, wdata, rdata_o all 0.
  - Read tag pipeline cleared.
  - last_gnt = 1, so requester 0 wins the first contention.
- Handshake:
  - The requester holds req/we/addr/wdata stable until its gnt bit is seen high.
  - It may drop or change the request in the cycle after gnt.
- Command timing:
  - A request granted in cycle t appears on write/read/addr/wdata in cycle t+1, for exactly one cycle.
  - Cycles with no grant drive write = read = 0; addr and wdata hold their previous values.
- Arbitration:
  - Only eligible requesters compete.
  - If both are eligible, grant the one that is not last_gnt.
  - last_gnt updates only on an actual grant.
- Eligibility:
  - req[i] is high, and it is not a write-hazard.
  - Write-hazard: we[i]=1, and the command issuing this cycle is a write, and req_addrI == addr.
  - A hazarded requester is skipped for one cycle. The other requester may take the slot; otherwise the cycle idles.
  - Reads are never hazarded.
  - A read to an address written in the previous cycle is allowed; the memory orders it.
- Read return:
  - A read issued on the bus in cycle u (read=1) returns in cycle u+RD_LAT.
  - In that cycle rvalid[id] = 1, rdata_o = rdata, rd_served = 1.
  - With RD_LAT = 0 this path is combinational from rdata.
  - Implement as a shift register of depth RD_LAT+1, each entry {valid, id}.
  - Reads and writes can be back-to-back; returns never collide because at most one command issues per cycle.
- Simultaneous events:
  - When a read return and a new grant fall in the same cycle, both proceed independently.
- Reset mid-operation:
  - In-flight read tags are discarded; no rvalid is produced for them.
  - Outstanding requests re-arbitrate from the reset state.
- Guaranteed properties:
  - gnt is at most one-hot.
  - write and read are never both high.
  - The same cycle as a grant never causes a second grant.

Decomposition:
- Package mem_sched_pkg holds:
  - typedef cmd_t {write, read, addr, wdata};
  - typedef rtag_t {valid, id};
  - constant NREQ = 2.
- Sub-module rd_tag_pipe(RD_LAT): the tag shift register and the rvalid decode.

Test Plan:
1. Reset, then req=2'b01, we0=0, addr0=0x10, RD_LAT=2, memory returns 0xAB: gnt=01 at t, read=1 with addr=0x10 at t+1, rvalid=01 and rdata_o=0xAB at t+3.
2. Both requesters hold reads continuously for 4 cycles: gnt sequence 01, 10, 01, 10; no cycle with two grants.
3. Requester 0 writes 0x20 twice in a row, requester 1 idle: write pulses at t+1 and t+3, one idle cycle between; the checker passes.
4. Requester 0 writes 0x20 then 0x20 again while requester 1 reads 0x30: the sequence on the bus is write 0x20, read 0x30, write 0x20, with no idle cycle.
5. RD_LAT=0, alternating reads from requesters 0 and 1: rvalid matches the issuing id in the same cycle as read, and rd_served tracks it.
6. Assert rst for 1 cycle while two reads are in flight (RD_LAT=3): no rvalid follows; all outputs are 0 the cycle after reset.
